// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, one outstanding imem request, IF/ID slot with a one-entry skid.
// Define IF_PERF_CNT_EN to add the fetch_cnt/drop_cnt performance counters.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PC_o,
    output logic [31:0] Instr_o,
    output logic        valid_o,
    output logic        flush_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;

    logic        w_consume;
    logic        w_slot_free;
    logic        w_req_valid;
    logic        w_req_hs;
    logic        w_rsp_take;
    logic        w_rsp_drop;
    logic        w_to_slot;
    logic        w_to_skid;
    logic        w_drain;
    logic [31:0] w_redirect_target;

    assign w_consume         = r_valid & ~stall;
    assign w_slot_free       = ~r_valid | ~stall;
    assign w_req_valid       = (r_state == S_REQ) & ~r_skid_valid & ~redirect;
    assign w_req_hs          = w_req_valid & imem_req_ready;
    assign w_rsp_take        = (r_state == S_WAIT) & imem_rsp_valid & ~redirect;
    assign w_rsp_drop        = imem_rsp_valid & (((r_state == S_WAIT) & redirect) | (r_state == S_DROP));
    assign w_to_slot         = w_rsp_take & w_slot_free & ~r_skid_valid;
    assign w_to_skid         = w_rsp_take & ~w_to_slot;
    assign w_drain           = r_skid_valid & w_slot_free & ~redirect;
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_hs) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid)  w_next_state = S_REQ;
                else if (redirect)   w_next_state = S_DROP;
            end
            S_DROP: begin
                // The stale response retires the outstanding request even if another redirect lands with it.
                if (imem_rsp_valid) w_next_state = S_REQ;
            end
            default: w_next_state = S_REQ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fetch_pc   <= RESET_PC;
            r_pc         <= 32'h0;
            r_instr      <= 32'h0;
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc   <= w_redirect_target;
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_rsp_take) r_fetch_pc <= r_req_pc + 32'd4;
            if (w_to_slot) begin
                r_pc    <= r_req_pc;
                r_instr <= imem_rsp_data;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_pc         <= r_skid_pc;
                r_instr      <= r_skid_instr;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
            if (w_to_skid) r_skid_valid <= 1'b1;
        end
    end

    // NOTE: payload registers are qualified by state or a valid bit, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (w_req_hs) r_req_pc <= r_fetch_pc;
        if (w_to_skid) begin
            r_skid_pc    <= r_req_pc;
            r_skid_instr <= imem_rsp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_drop_cnt;
    logic [1:0]  w_drop_inc;

    // A redirect can kill a presented instruction and a late response in the same cycle.
    assign w_drop_inc = {1'b0, w_rsp_drop} + {1'b0, redirect & r_valid} + {1'b0, redirect & r_skid_valid};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fetch_cnt <= 32'h0;
            r_drop_cnt  <= 32'h0;
        end else begin
            if (w_to_slot | w_to_skid) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            r_drop_cnt <= r_drop_cnt + {30'h0, w_drop_inc};
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign PC_o           = r_pc;
    assign Instr_o        = r_instr;
    assign valid_o        = r_valid;
    assign flush_o        = redirect;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: per-cycle vector tables, a latency-programmable memory
// model, and a scoreboard of expected {PC, Instr} popped whenever decode consumes an instruction.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam time HALF = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] PC_o;
    logic [31:0] Instr_o;
    logic        valid_o;
    logic        flush_o;

    // Second instance with RESET_PC at the top of the address space.
    logic        stall_b;
    logic        redirect_b;
    logic [31:0] redirect_pc_b;
    logic        req_valid_b;
    logic        req_ready_b;
    logic [31:0] req_addr_b;
    logic        rsp_valid_b;
    logic [31:0] rsp_data_b;
    logic [31:0] pc_b;
    logic [31:0] instr_b;
    logic        valid_b;
    logic        flush_b;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] fetch_cnt_b;
    logic [31:0] drop_cnt_b;
`endif

    always #HALF CLK = ~CLK;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .CLK(CLK), .RESET(RESET), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .PC_o(PC_o), .Instr_o(Instr_o), .valid_o(valid_o), .flush_o(flush_o)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_top (
        .CLK(CLK), .RESET(RESET), .stall(stall_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .imem_req_valid(req_valid_b), .imem_req_ready(req_ready_b), .imem_req_addr(req_addr_b),
        .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
        .PC_o(pc_b), .Instr_o(instr_b), .valid_o(valid_b), .flush_o(flush_b)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt_b), .drop_cnt(drop_cnt_b)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } cyc_vec_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
    } rd_vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [31:0] hs_q[$];
    logic [31:0] hs2_q[$];
    logic [31:0] pc2_q[$];

    int          mem_lat = 1;
    bit          mem_pend = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'h0;
    bit          hs_now;
    logic [31:0] hs_addr_now;
    bit          hs2_now;
    logic [31:0] hs2_addr_now;

    cyc_vec_t    flow_vec[15];
    rd_vec_t     rd_vec[4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb_q.push_back(e);
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock cycle: sample pre-edge outputs, cross the edge, then drive memory responses for the next cycle.
    task automatic tick();
        exp_t e;
        #1;
        hs_now  = 1'b0;
        hs2_now = 1'b0;
        if (RESET) begin
            if (imem_req_valid && imem_req_ready) begin
                hs_now      = 1'b1;
                hs_addr_now = imem_req_addr;
                hs_q.push_back(imem_req_addr);
            end
            if (valid_o && !stall) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got PC %h, required no instruction", PC_o);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", PC_o, e.pc);
                    check("sb_instr", Instr_o, e.instr);
                end
            end
            if (req_valid_b && req_ready_b) begin
                hs2_now      = 1'b1;
                hs2_addr_now = req_addr_b;
                if (hs2_q.size() < 4) hs2_q.push_back(req_addr_b);
            end
            if (valid_b && pc2_q.size() < 4) pc2_q.push_back(pc_b);
        end
        @(posedge CLK);
        @(negedge CLK);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0BAD_0BAD;
        rsp_valid_b    = 1'b0;
        rsp_data_b     = 32'h0BAD_0BAD;
        if (!RESET) begin
            mem_pend = 1'b0;
        end else begin
            if (hs_now) begin
                mem_pend = 1'b1;
                mem_addr = hs_addr_now;
                mem_wait = mem_lat;
            end
            if (mem_pend) begin
                mem_wait--;
                if (mem_wait == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                    mem_pend       = 1'b0;
                end
            end
            if (hs2_now) begin
                rsp_valid_b = 1'b1;
                rsp_data_b  = mem_word(hs2_addr_now);
            end
        end
    endtask

    task automatic wait_consume(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) tick();
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required the bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle-by-cycle trace from reset release: k=1, ready=1, then a 5-cycle stall at PC 0x8.
        flow_vec[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        flow_vec[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        flow_vec[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        flow_vec[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        flow_vec[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        flow_vec[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        flow_vec[6]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        flow_vec[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        flow_vec[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        flow_vec[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        flow_vec[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        flow_vec[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
        flow_vec[12] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        flow_vec[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        flow_vec[14] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};

        rd_vec[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
        rd_vec[1] = '{32'h1234_5677, 32'h1234_5674};
        rd_vec[2] = '{32'h8000_0002, 32'h8000_0000};
        rd_vec[3] = '{32'h0000_0021, 32'h0000_0020};

        RESET          = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall_b        = 1'b0;
        redirect_b     = 1'b0;
        redirect_pc_b  = 32'h0;
        req_ready_b    = 1'b1;
        rsp_valid_b    = 1'b0;
        rsp_data_b     = 32'h0;

        repeat (2) @(negedge CLK);
        check("rst_valid", valid_o, 1'b0);
        check("rst_pc", PC_o, 32'h0);
        check("rst_instr", Instr_o, 32'h0);
        check("rst_flush", flush_o, 1'b0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_top_req_addr", req_addr_b, 32'hFFFF_FFFC);

        // Basic streaming plus stall/skid behaviour.
        RESET          = 1'b1;
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        for (int p = 0; p <= 32'h14; p += 4) expect_fetch(p);
        for (int i = 0; i < 15; i++) begin
            stall = flow_vec[i].stall;
            settle();
            check($sformatf("flow%0d_req_valid", i), imem_req_valid, flow_vec[i].exp_req_valid);
            if (flow_vec[i].exp_req_valid) check($sformatf("flow%0d_req_addr", i), imem_req_addr, flow_vec[i].exp_addr);
            check($sformatf("flow%0d_valid", i), valid_o, flow_vec[i].exp_valid);
            if (flow_vec[i].exp_valid) begin
                check($sformatf("flow%0d_pc", i), PC_o, flow_vec[i].exp_pc);
                check($sformatf("flow%0d_instr", i), Instr_o, mem_word(flow_vec[i].exp_pc));
            end
            tick();
        end
        stall          = 1'b0;
        imem_req_ready = 1'b0;
        wait_consume("flow_drain", 8);

        // Redirect in S_WAIT; the response shows up two cycles later and must be dropped.
        settle();
        check("w_req_addr", imem_req_addr, 32'h18);
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0103;
        settle();
        check("w_flush", flush_o, 1'b1);
        check("w_req_blocked", imem_req_valid, 1'b0);
        tick();
        redirect = 1'b0;
        settle();
        check("w_flush_clear", flush_o, 1'b0);
        check("w_drop_req_valid", imem_req_valid, 1'b0);
        check("w_drop_valid", valid_o, 1'b0);
        tick();
        settle();
        check("w_late_rsp_req_valid", imem_req_valid, 1'b0);
        check("w_late_rsp_valid", valid_o, 1'b0);
        tick();
        settle();
        check("w_retarget_req_valid", imem_req_valid, 1'b1);
        check("w_retarget_addr", imem_req_addr, 32'h0000_0100);
        check("w_retarget_valid", valid_o, 1'b0);
        expect_fetch(32'h100);
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        wait_consume("w_fetch_100", 8);

        // Redirect coincides with the response: no S_DROP visit, target requested next cycle.
        mem_lat        = 2;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        settle();
        check("c_flush", flush_o, 1'b1);
        tick();
        redirect = 1'b0;
        settle();
        check("c_req_valid", imem_req_valid, 1'b1);
        check("c_req_addr", imem_req_addr, 32'h0000_0200);
        check("c_valid", valid_o, 1'b0);
        expect_fetch(32'h200);
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        wait_consume("c_fetch_200", 8);

        // Redirect target alignment while idle in S_REQ.
        for (int i = 0; i < 4; i++) begin
            redirect    = 1'b1;
            redirect_pc = rd_vec[i].target;
            settle();
            check($sformatf("rd%0d_flush", i), flush_o, 1'b1);
            check($sformatf("rd%0d_req_blocked", i), imem_req_valid, 1'b0);
            tick();
            redirect = 1'b0;
            settle();
            check($sformatf("rd%0d_flush_clear", i), flush_o, 1'b0);
            check($sformatf("rd%0d_req_valid", i), imem_req_valid, 1'b1);
            check($sformatf("rd%0d_req_addr", i), imem_req_addr, rd_vec[i].exp_addr);
            tick();
        end

        // Request held stable through three not-ready cycles, handshake on the fourth.
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("hold%0d_req_valid", i), imem_req_valid, 1'b1);
            check($sformatf("hold%0d_req_addr", i), imem_req_addr, 32'h20);
            tick();
        end
        hs_q.delete();
        stall          = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("hold_hs_count", hs_q.size(), 1);
        check("hold_hs_addr", hs_q[0], 32'h20);
        tick();
        settle();
        check("stall_valid", valid_o, 1'b1);
        check("stall_pc", PC_o, 32'h20);
        check("stall_instr", Instr_o, mem_word(32'h20));

        // Redirect beats stall and kills the presented instruction.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        settle();
        check("rs_flush", flush_o, 1'b1);
        tick();
        redirect = 1'b0;
        settle();
        check("rs_valid_killed", valid_o, 1'b0);
        check("rs_req_addr", imem_req_addr, 32'h40);

        // Asynchronous reset in S_WAIT with a stalled valid instruction.
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        tick();
        mem_lat = 3;
        tick();
        tick();
        imem_req_ready = 1'b0;
        settle();
        check("ar_pre_valid", valid_o, 1'b1);
        check("ar_pre_pc", PC_o, 32'h40);
        RESET = 1'b0;
        settle();
        check("ar_valid", valid_o, 1'b0);
        check("ar_pc", PC_o, 32'h0);
        check("ar_instr", Instr_o, 32'h0);
        check("ar_flush", flush_o, 1'b0);
        check("ar_req_addr", imem_req_addr, 32'h0);
        tick();
        RESET = 1'b1;
        stall = 1'b0;
        settle();
        check("ar_post_req_valid", imem_req_valid, 1'b1);
        check("ar_post_req_addr", imem_req_addr, 32'h0);
        expect_fetch(32'h0);
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        wait_consume("ar_refetch", 8);

        // Top-of-memory instance: PC wraps from 0xFFFF_FFFC to 0.
        check("top_hs_count", hs2_q.size() >= 2, 1'b1);
        check("top_hs0", hs2_q[0], 32'hFFFF_FFFC);
        check("top_hs1", hs2_q[1], 32'h0000_0000);
        check("top_pc0", pc2_q[0], 32'hFFFF_FFFC);
        check("top_pc1", pc2_q[1], 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage of the RISC-V core and the producer side of the IF/ID pipeline register. It generates the fetch PC, issues requests to instruction memory over a valid/ready request channel, and receives responses on a non-backpressurable response channel. It presents {PC, Instr, valid} to IF/ID and holds them while decode is stalled. It applies branch/jump redirects, drives the IF/ID flush and discards stale responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-low reset.
stall  input  1  decode not accepting; the presented instruction must be held.
redirect  input  1  one-cycle pulse; branch/jump taken.
redirect_pc  input  32  new fetch target; bits [1:0] ignored, forced to 0.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request.
imem_req_addr  output  32  fetch address, word-aligned.
imem_rsp_valid  input  1  one-cycle response pulse; cannot be backpressured.
imem_rsp_data  input  32  instruction word.
PC_o  output  32  PC of the presented instruction; feeds the IF/ID PC input.
Instr_o  output  32  presented instruction; feeds the IF/ID Instr input.
valid_o  output  1  PC_o/Instr_o hold a real instruction.
flush_o  output  1  drives the IF/ID flush input.

Behaviour:
- Single outstanding request. FSM states: S_REQ, S_WAIT, S_DROP.
- Registers: fetch_pc, req_pc, output slot {PC_o, Instr_o, valid_o}, one-entry skid {skid_valid, skid_pc, skid_instr}.
- Reset (RESET=0, async): state=S_REQ; fetch_pc=RESET_PC; PC_o=0; Instr_o=0; valid_o=0; skid_valid=0.
- Reset deasserted mid-transaction: any in-flight response is simply lost. Memory is reset by the same RESET.
- consume = valid_o & !stall. slot_free = !valid_o | !stall.
- If consume occurs and nothing loads the slot that cycle, valid_o<=0. PC_o/Instr_o keep their values; downstream ignores them.
- S_REQ:
  - imem_req_valid = !skid_valid & !redirect; imem_req_addr = fetch_pc.
  - On a req handshake: req_pc<=fetch_pc, go to S_WAIT.
  - imem_req_valid and imem_req_addr are held stable until the handshake, unless a redirect occurs.
- S_WAIT, on imem_rsp_valid (no redirect):
  - If slot_free and !skid_valid: slot<={req_pc, rsp_data}, valid_o<=1.
  - Otherwise: skid<={req_pc, rsp_data}, skid_valid<=1.
  - In both cases fetch_pc<=req_pc+4 and go to S_REQ.
- Skid drain: if skid_valid and slot_free, slot<=skid, valid_o<=1, skid_valid<=0.
  - Requests are blocked while skid_valid=1, so a response and a drain never collide.
- Latency: request handshake at cycle N with memory response at N+k gives valid_o=1 at N+k+1.
- Back-to-back fetch with no stall: request issued the cycle after the response, so throughput is one instruction per k+1 cycles.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Redirect (highest priority, any state):
  - flush_o = redirect (combinational, same cycle).
  - fetch_pc<={redirect_pc[31:2],2'b00}; valid_o<=0; skid_valid<=0; imem_req_valid=0 that cycle.
  - In S_REQ: stay in S_REQ. The request to the new target is issued the next cycle.
  - In S_WAIT with rsp_valid in the same cycle: discard the response, go to S_REQ.
  - In S_WAIT without rsp_valid: go to S_DROP.
  - In S_DROP: update fetch_pc, stay in S_DROP.
- S_DROP: imem_req_valid=0. On rsp_valid, discard the response (no slot or skid write), go to S_REQ.
- Redirect and stall together: redirect wins; the slot is invalidated regardless of stall.
- flush_o=0 whenever redirect=0.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and drop_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_cnt increments once per response written to the slot or skid.
  - drop_cnt increments per response discarded in S_DROP or in S_WAIT-with-redirect, plus 1 per valid slot or skid entry killed by a redirect.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory latency k=1, ready=1, no stall -> requests at 0x0, 0x4, 0x8; valid_o pulses with PC_o=0x0, 0x4, 0x8 and Instr_o equal to the memory words, one instruction per 2 cycles.
- stall=1 held for 5 cycles while valid_o=1 at PC 0x8 -> PC_o/Instr_o stable. Response for 0xC goes to the skid and no further request is issued. On stall release, 0xC appears the next cycle and a request for 0x10 is issued.
- redirect with redirect_pc=0x0000_0103 while in S_WAIT, response arriving 2 cycles later -> flush_o=1 that cycle, the late response is discarded, the next request address is 0x0000_0100, and valid_o=0 until 0x100 returns.
- redirect in the same cycle as rsp_valid -> response discarded; the next cycle requests the redirect target; no S_DROP visit.
- imem_req_ready=0 for 3 cycles in S_REQ at fetch_pc=0x20 -> imem_req_valid=1 and imem_req_addr=0x20 held stable; handshake on cycle 4.
- RESET_PC=32'hFFFF_FFFC -> second request address is 0x0000_0000. Assert RESET mid-S_WAIT -> all outputs return to 0 immediately and state is S_REQ.
